setpoint_thermostat_ctrl: RTL and testbench
===========================================

// Module: setpoint_thermostat_ctrl
// PURPOSE
//  Parametrised set-point and thermostat controller between the DHT11 reader and the 7-seg driver.
//  Debounces the inc/dec/mode inputs and edits a clamped set-point in a shadow register, with auto-repeat on held buttons.
//  Compares each valid sensor sample against the committed set-point with hysteresis.
//  Drives heat/cool requests, a match flag, a sensor-stale flag and the value to display.
// PARAMETERS
//  DATA_W        8          width of temperature and set-point values (unsigned)
//  SET_MIN       0          lowest legal set-point
//  SET_MAX       50         highest legal set-point
//  SET_DEFAULT   25         set-point after reset; must lie in [SET_MIN,SET_MAX]
//  HYST          1          hysteresis band, same units as temp
//  DEBOUNCE_CYC  1000000    stable cycles before a button level is accepted (10 ms at 100 MHz)
//  REPEAT_DELAY  50000000   held cycles before the first auto-repeat step
//  REPEAT_RATE   10000000   cycles between subsequent auto-repeat steps
//  STALE_CYC     300000000  cycles without temp_valid_i before the sample is declared stale
// PORTS
//  clk_i          in   1       system clock, 100 MHz
//  rst_i          in   1       synchronous reset, active-high
//  mode_switch    in   1       async: 0 = READ mode, 1 = SET mode
//  btn_inc        in   1       async increment button, active-high
//  btn_dec        in   1       async decrement button, active-high
//  temp_i         in   DATA_W  temperature from the DHT11 reader
//  temp_valid_i   in   1       1-cycle strobe; temp_i is valid on this cycle
//  setpoint_o     out  DATA_W  committed set-point
//  disp_value_o   out  DATA_W  SET mode: shadow set-point; READ mode: last sample
//  disp_set_o     out  1       1 when disp_value_o shows the set-point
//  heat_o         out  1       heat request
//  cool_o         out  1       cool request
//  match_o        out  1       last sample == committed set-point, and the sample is not stale
//  stale_o        out  1       no valid sample within STALE_CYC cycles, or none since reset
// BEHAVIOUR
//  Reset values
//   - setpoint_o = shadow = SET_DEFAULT; temp_q = 0; FSM = IDLE.
//   - heat_o = cool_o = match_o = 0; stale_o = 1; disp_set_o = 0; debouncers read released.
//  Input conditioning
//   - Each async input passes a 2-flop synchroniser, then the debouncer.
//   - A debounced level changes after DEBOUNCE_CYC consecutive equal synchronised samples.
//  Stepping (SET mode only)
//   - Debounced rising edge gives one step pulse.
//   - Still held: one pulse REPEAT_DELAY cycles after the edge, then one every REPEAT_RATE cycles.
//   - inc and dec pulses on the same cycle cancel; no change.
//   - Shadow saturates at SET_MAX/SET_MIN and never wraps.
//   - In READ mode, button pulses are ignored.
//  Mode and commit
//   - Debounced SET->READ edge: shadow -> setpoint_o on the next cycle.
//   - Debounced READ->SET edge: shadow reloads from setpoint_o.
//   - Control keeps using the committed set-point while in SET mode.
//  Sample handling
//   - temp_q <= temp_i on temp_valid_i.
//   - The stale counter clears on temp_valid_i; stale_o = 1 when it reaches STALE_CYC.
//   - stale_o clears the cycle after the next temp_valid_i.
//  Control FSM (state and outputs registered; 1-cycle latency from temp_q/setpoint change)
//   - Comparisons are done at DATA_W+1 bits, with no underflow.
//   - IDLE -> HEAT when temp_q + HYST < set.
//   - IDLE -> COOL when temp_q > set + HYST.
//   - HEAT -> IDLE when temp_q >= set.
//   - COOL -> IDLE when temp_q <= set.
//   - Any state -> IDLE while stale_o = 1.
//   - heat_o = (state == HEAT); cool_o = (state == COOL).
//  Reset mid-operation
//   - rst_i overrides everything, including an in-progress debounce, repeat or commit.
// STRUCTURE
//  Package thermo_pkg
//   - typedef ctrl_state_t {IDLE, HEAT, COOL}.
//   - Default timing constants for 100 MHz.
//  Sub-module btn_debounce (sync + debounce + edge + auto-repeat, params DEBOUNCE_CYC/REPEAT_*)
//   - Instantiated for inc and dec.
//   - Also instantiated for mode, with repeat disabled via REPEAT_DELAY = 0.
//  Remainder of this file: shadow/commit registers, stale counter, control FSM, display mux.
// TESTING (sim params: DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=5, STALE_CYC=200)
//  1. Reset; SET mode; 3 clean inc presses; return to READ.
//     -> shadow 25->28; setpoint_o = 28 one cycle after the debounced READ edge.
//  2. inc held 40 cycles at shadow 48 -> pulses at edge, +20, +25, ...; shadow saturates at 50.
//     Also: dec pulses at SET_MIN stay at 0; inc+dec on the same cycle leave the shadow unchanged.
//  3. Glitches on btn_inc shorter than 4 cycles, in SET mode -> no step.
//     Any btn press in READ mode -> setpoint_o unchanged.
//  4. set=25: temp 23 -> heat_o; 24 -> heat_o held; 25 -> heat_o=0, match_o=1.
//     Then temp 27 -> cool_o; 26 -> cool_o held.
//  5. No temp_valid_i for 200 cycles -> stale_o=1, heat_o/cool_o/match_o=0.
//     The next valid sample clears stale_o the following cycle.
//  6. Assert rst_i mid auto-repeat in SET mode -> all outputs return to their reset values.
//     No spurious step follows reset release while the button is still held.

Source files
------------

// File: rtl/setpoint_thermostat_ctrl_pkg.sv
// Shared types and default timing constants for the set-point / thermostat controller.
package setpoint_thermostat_ctrl_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2
    } ctrl_state_t;

    // Internal observation bundle: FSM state, edit mode and debounced button levels.
    typedef struct packed {
        ctrl_state_t state;
        logic        set_mode;
        logic        inc_level;
        logic        dec_level;
    } dbg_t;

    // Default timing for a 100 MHz clock.
    localparam int DEF_DEBOUNCE_CYC = 1000000;   // 10 ms
    localparam int DEF_REPEAT_DELAY = 50000000;  // 500 ms
    localparam int DEF_REPEAT_RATE  = 10000000;  // 100 ms
    localparam int DEF_STALE_CYC    = 300000000; // 3 s

    // Width of a counter that must hold the values 0 .. n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/setpoint_thermostat_ctrl_if.sv
// Signal bundle between the controller and its surroundings (sensor, buttons, display).
// Handshake: temp_valid_i is a one-cycle strobe with no back-pressure; temp_i is only
// meaningful on the cycle temp_valid_i is high. Buttons and mode_switch are asynchronous levels.
interface setpoint_thermostat_ctrl_if
    import setpoint_thermostat_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic              mode_switch;
    logic              btn_inc;
    logic              btn_dec;
    logic [DATA_W-1:0] temp_i;
    logic              temp_valid_i;
    logic [DATA_W-1:0] setpoint_o;
    logic [DATA_W-1:0] disp_value_o;
    logic              disp_set_o;
    logic              heat_o;
    logic              cool_o;
    logic              match_o;
    logic              stale_o;
    dbg_t              dbg;

    // Driver side: buttons, mode switch and sensor samples.
    modport master (
        output mode_switch, btn_inc, btn_dec, temp_i, temp_valid_i,
        input  setpoint_o, disp_value_o, disp_set_o, heat_o, cool_o, match_o, stale_o, dbg
    );

    // Controller side.
    modport slave (
        input  mode_switch, btn_inc, btn_dec, temp_i, temp_valid_i,
        output setpoint_o, disp_value_o, disp_set_o, heat_o, cool_o, match_o, stale_o, dbg
    );
endinterface

// File: rtl/setpoint_thermostat_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, level debouncer, rising-edge step pulse and
// optional auto-repeat while held. REPEAT_DELAY = 0 turns auto-repeat off.
module btn_debounce
    import setpoint_thermostat_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic step_o
);
    localparam int DB_W  = cnt_width(DEBOUNCE_CYC);
    localparam int REP_W = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = (REPEAT_DELAY > 0) ? REP_W'(REPEAT_DELAY - 1) : '0;
    localparam logic [REP_W-1:0] RATE_LAST  = (REPEAT_RATE > 0) ? REP_W'(REPEAT_RATE - 1) : '0;

    logic [1:0]       sync_q;
    logic             level_q;
    logic             level_d_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [REP_W-1:0] rep_cnt_q;
    logic             repeating_q;
    logic             step_q;
    logic [REP_W-1:0] rep_last;

    // First repeat waits REPEAT_DELAY cycles after the edge, later ones REPEAT_RATE.
    assign rep_last = repeating_q ? RATE_LAST : DELAY_LAST;

    // Synchronise, then accept a new level only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= 2'b00;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            if (sync_q[1] == level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_q  <= sync_q[1];
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // One step on the debounced rising edge, then auto-repeat steps while the level stays high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_d_q   <= 1'b0;
            step_q      <= 1'b0;
            rep_cnt_q   <= '0;
            repeating_q <= 1'b0;
        end else begin
            level_d_q <= level_q;
            step_q    <= 1'b0;
            if (level_q && !level_d_q) begin
                step_q      <= 1'b1;
                rep_cnt_q   <= '0;
                repeating_q <= 1'b0;
            end else if (level_q && (REPEAT_DELAY > 0)) begin
                if (rep_cnt_q == rep_last) begin
                    step_q      <= 1'b1;
                    rep_cnt_q   <= '0;
                    repeating_q <= 1'b1;
                end else begin
                    rep_cnt_q <= rep_cnt_q + 1'b1;
                end
            end
        end
    end

    assign level_o = level_q;
    assign step_o  = step_q;
endmodule

// File: rtl/setpoint_thermostat_ctrl.sv
// Set-point editor and hysteresis thermostat sitting between the DHT11 reader and the
// 7-segment driver. Edits happen in a shadow register and are committed on leaving SET mode.
module setpoint_thermostat_ctrl
    import setpoint_thermostat_ctrl_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int SET_MIN      = 0,
    parameter int SET_MAX      = 50,
    parameter int SET_DEFAULT  = 25,
    parameter int HYST         = 1,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int STALE_CYC    = DEF_STALE_CYC
) (
    input logic                       clk_i,
    input logic                       rst_i,
    setpoint_thermostat_ctrl_if.slave bus
);
    localparam logic [DATA_W-1:0] MIN_V   = DATA_W'(SET_MIN);
    localparam logic [DATA_W-1:0] MAX_V   = DATA_W'(SET_MAX);
    localparam logic [DATA_W-1:0] DEF_V   = DATA_W'(SET_DEFAULT);
    localparam logic [DATA_W:0]   HYST_X  = (DATA_W + 1)'(HYST);
    localparam int                STALE_W = cnt_width(STALE_CYC);
    localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CYC - 1);

    logic inc_level, inc_step, dec_level, dec_step, mode_level, mode_step;

    logic [DATA_W-1:0]  shadow_q, setpoint_q, temp_q;
    logic               set_mode_q;
    logic [STALE_W-1:0] stale_cnt_q;
    logic               stale_q;
    ctrl_state_t        state_q;
    logic               heat_q, cool_q, match_q;
    logic [DATA_W:0]    temp_x, set_x;
    logic               leave_set;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_inc (.clk_i(clk_i), .rst_i(rst_i), .btn_i(bus.btn_inc), .level_o(inc_level), .step_o(inc_step));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_dec (.clk_i(clk_i), .rst_i(rst_i), .btn_i(bus.btn_dec), .level_o(dec_level), .step_o(dec_step));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY(0), .REPEAT_RATE(1))
        u_mode (.clk_i(clk_i), .rst_i(rst_i), .btn_i(bus.mode_switch), .level_o(mode_level), .step_o(mode_step));

    // Debounced SET->READ transition: commit the shadow value this cycle.
    assign leave_set = set_mode_q && !mode_level;

    // Edit mode tracking, shadow editing with saturation, and commit to the live set-point.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            set_mode_q <= 1'b0;
            shadow_q   <= DEF_V;
            setpoint_q <= DEF_V;
        end else begin
            if (leave_set) begin
                set_mode_q <= 1'b0;
                setpoint_q <= shadow_q;
            end else if (mode_step) begin
                // Entering SET mode: start editing from the committed value.
                set_mode_q <= 1'b1;
                shadow_q   <= setpoint_q;
            end else if (set_mode_q) begin
                if (inc_step && !dec_step && (shadow_q < MAX_V)) begin
                    shadow_q <= shadow_q + 1'b1;
                end else if (dec_step && !inc_step && (shadow_q > MIN_V)) begin
                    shadow_q <= shadow_q - 1'b1;
                end
            end
        end
    end

    // Latch each valid sample and track how long since the last one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            temp_q      <= '0;
            stale_cnt_q <= '0;
            stale_q     <= 1'b1;
        end else if (bus.temp_valid_i) begin
            temp_q      <= bus.temp_i;
            stale_cnt_q <= '0;
            stale_q     <= 1'b0;
        end else if (stale_cnt_q == STALE_LAST) begin
            stale_q <= 1'b1;
        end else begin
            stale_cnt_q <= stale_cnt_q + 1'b1;
        end
    end

    // One extra bit so temp + HYST and set + HYST cannot wrap.
    assign temp_x = {1'b0, temp_q};
    assign set_x  = {1'b0, setpoint_q};

    // Hysteresis control FSM with registered heat/cool/match outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            heat_q  <= 1'b0;
            cool_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            match_q <= !stale_q && (temp_q == setpoint_q);
            if (stale_q) begin
                state_q <= IDLE;
                heat_q  <= 1'b0;
                cool_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (temp_x + HYST_X < set_x) begin
                            state_q <= HEAT;
                            heat_q  <= 1'b1;
                        end else if (temp_x > set_x + HYST_X) begin
                            state_q <= COOL;
                            cool_q  <= 1'b1;
                        end
                    end
                    HEAT: begin
                        if (temp_x >= set_x) begin
                            state_q <= IDLE;
                            heat_q  <= 1'b0;
                        end
                    end
                    COOL: begin
                        if (temp_x <= set_x) begin
                            state_q <= IDLE;
                            cool_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        heat_q  <= 1'b0;
                        cool_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.setpoint_o   = setpoint_q;
    assign bus.disp_set_o   = set_mode_q;
    assign bus.disp_value_o = set_mode_q ? shadow_q : temp_q;
    assign bus.heat_o       = heat_q;
    assign bus.cool_o       = cool_q;
    assign bus.match_o      = match_q;
    assign bus.stale_o      = stale_q;
    assign bus.dbg          = {state_q, set_mode_q, inc_level, dec_level};
endmodule

// File: tb/tb_setpoint_thermostat_ctrl.sv
// Bench for setpoint_thermostat_ctrl with short timing constants and a behavioural model.
module tb_setpoint_thermostat_ctrl;
    import setpoint_thermostat_ctrl_pkg::*;

    localparam int DB    = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 5;
    localparam int STALE = 200;
    localparam int SMIN  = 0;
    localparam int SMAX  = 50;
    localparam int SDEF  = 25;
    localparam int HYS   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    logic [31:0] exp_q[$];

    // Model state
    int m_shadow, m_setpoint, m_temp;
    bit m_stale, m_heat, m_cool;

    setpoint_thermostat_ctrl_if #(.DATA_W(8)) bus ();

    setpoint_thermostat_ctrl #(
        .DATA_W(8), .SET_MIN(SMIN), .SET_MAX(SMAX), .SET_DEFAULT(SDEF), .HYST(HYS),
        .DEBOUNCE_CYC(DB), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .STALE_CYC(STALE)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Number of step pulses a press held for d debounced cycles must produce.
    function automatic int pulses(input int d);
        if (d <= DELAY) return 1;
        return 2 + (d - 1 - DELAY) / RATE;
    endfunction

    function automatic int clamp(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Hysteresis model: settle heating/cooling flags for the current sample.
    task automatic model_ctrl();
        for (int k = 0; k < 2; k++) begin
            if (m_stale) begin
                m_heat = 0;
                m_cool = 0;
            end else if (m_heat) begin
                if (m_temp >= m_setpoint) m_heat = 0;
            end else if (m_cool) begin
                if (m_temp <= m_setpoint) m_cool = 0;
            end else if (m_temp + HYS < m_setpoint) begin
                m_heat = 1;
            end else if (m_temp > m_setpoint + HYS) begin
                m_cool = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        m_shadow = SDEF;
        m_setpoint = SDEF;
        m_temp = 0;
        m_stale = 1;
        m_heat = 0;
        m_cool = 0;
    endtask

    task automatic wait_disp_set(input logic val, input int budget);
        for (int i = 0; i < budget && bus.disp_set_o !== val; i++) tick(1);
        check("disp_set_wait", bus.disp_set_o, val);
    endtask

    // Hold inc/dec for d cycles, release, let the debouncer settle; update the model.
    task automatic press(input bit inc, input bit dec, input int d, input bit set_mode);
        int p;
        bus.btn_inc = inc;
        bus.btn_dec = dec;
        tick(d);
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        tick(DB + 10);
        p = pulses(d);
        if (set_mode && !(inc && dec)) m_shadow = clamp(inc ? m_shadow + p : m_shadow - p);
    endtask

    task automatic glitches(input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_inc = 1'b1;
            tick($urandom_range(1, DB - 1));
            bus.btn_inc = 1'b0;
            tick($urandom_range(3, 6));
        end
        tick(DB + 10);
    endtask

    task automatic send_temp(input int t);
        bus.temp_i = 8'(t);
        bus.temp_valid_i = 1'b1;
        tick(1);
        bus.temp_valid_i = 1'b0;
        m_temp = t;
        m_stale = 0;
    endtask

    task automatic check_ctrl(input string tag);
        model_ctrl();
        check({tag, "_heat"}, bus.heat_o, m_heat);
        check({tag, "_cool"}, bus.cool_o, m_cool);
        check({tag, "_match"}, bus.match_o, (!m_stale && m_temp == m_setpoint));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_setpoint"}, bus.setpoint_o, SDEF);
        check({tag, "_disp_value"}, bus.disp_value_o, 0);
        check({tag, "_disp_set"}, bus.disp_set_o, 0);
        check({tag, "_heat"}, bus.heat_o, 0);
        check({tag, "_cool"}, bus.cool_o, 0);
        check({tag, "_match"}, bus.match_o, 0);
        check({tag, "_stale"}, bus.stale_o, 1);
        check({tag, "_state"}, bus.dbg.state, IDLE);
    endtask

    initial begin
        int op, d, t;
        bus.mode_switch = 1'b0;
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        bus.temp_i = '0;
        bus.temp_valid_i = 1'b0;

        do_reset();
        check_reset_vals("reset");

        // Three clean inc presses in SET mode, then commit.
        bus.mode_switch = 1'b1;
        wait_disp_set(1'b1, 30);
        check("enter_disp", bus.disp_value_o, m_setpoint);
        for (int i = 0; i < 3; i++) press(1, 0, 6, 1);
        check("three_inc", bus.disp_value_o, 28);
        check("no_commit_in_set", bus.setpoint_o, SDEF);
        bus.mode_switch = 1'b0;
        wait_disp_set(1'b0, 30);
        m_setpoint = m_shadow;
        check("commit_28", bus.setpoint_o, 28);

        // Auto-repeat to 48, saturation at the top, long dec to the bottom.
        bus.mode_switch = 1'b1;
        wait_disp_set(1'b1, 30);
        press(1, 0, 113, 1);
        check("repeat_to_48", bus.disp_value_o, 48);
        press(1, 0, 40, 1);
        check("sat_max", bus.disp_value_o, SMAX);
        press(0, 1, 268, 1);
        check("dec_to_min", bus.disp_value_o, SMIN);
        press(0, 1, 6, 1);
        check("sat_min", bus.disp_value_o, SMIN);
        press(1, 1, 33, 1);
        check("inc_dec_cancel", bus.disp_value_o, m_shadow);

        // Randomised edits including glitches.
        for (int i = 0; i < 12; i++) begin
            op = $urandom_range(0, 3);
            d = ($urandom_range(0, 1) == 1) ? $urandom_range(6, 14) : 23 + 5 * $urandom_range(0, 4);
            if (op == 3) glitches($urandom_range(1, 4));
            else press(op != 1, op != 0, d, 1);
            exp_q.push_back(32'(m_shadow));
            check("rand_shadow", bus.disp_value_o, exp_q.pop_front());
        end
        bus.mode_switch = 1'b0;
        wait_disp_set(1'b0, 30);
        m_setpoint = m_shadow;
        check("rand_commit", bus.setpoint_o, m_setpoint);

        // Presses in READ mode are ignored.
        for (int i = 0; i < 4; i++) begin
            press($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(6, 30), 0);
            check("read_ignore", bus.setpoint_o, m_setpoint);
            check("read_disp", bus.disp_value_o, m_temp);
        end

        // Control loop around set-point 25.
        do_reset();
        send_temp(23); tick(3); check_ctrl("t23");
        send_temp(24); tick(3); check_ctrl("t24");
        send_temp(25); tick(3); check_ctrl("t25");
        send_temp(27); tick(3); check_ctrl("t27");
        send_temp(26); tick(3); check_ctrl("t26");
        send_temp(255); tick(3); check_ctrl("t255");
        send_temp(0); tick(3); check_ctrl("t0");
        for (int i = 0; i < 20; i++) begin
            t = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(20, 30);
            send_temp(t);
            tick($urandom_range(3, 8));
            check_ctrl("rand_temp");
            check("rand_disp_temp", bus.disp_value_o, m_temp);
        end

        // Staleness.
        send_temp(20);
        tick(3); check_ctrl("pre_stale");
        tick(187);
        check("not_yet_stale", bus.stale_o, 0);
        tick(20);
        m_stale = 1;
        check("stale_set", bus.stale_o, 1);
        check_ctrl("stale");
        send_temp(20);
        check("stale_clear", bus.stale_o, 0);
        tick(3); check_ctrl("post_stale");

        // Reset in the middle of an auto-repeat.
        bus.mode_switch = 1'b1;
        wait_disp_set(1'b1, 30);
        bus.btn_inc = 1'b1;
        tick(30);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_reset_vals("mid_rst");
        tick(15);
        check("rst_reenter_set", bus.disp_set_o, 1);
        check("rst_no_step", bus.disp_value_o, SDEF);
        bus.btn_inc = 1'b0;
        tick(15);
        check("rst_no_step_late", bus.disp_value_o, SDEF);
        bus.mode_switch = 1'b0;
        wait_disp_set(1'b0, 30);
        check("rst_setpoint", bus.setpoint_o, SDEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
